frame_buffer_rwm: RTL and testbench

- Parametrised pixel frame store between the grayscaling stage (writer) and downstream consumers (readers), sequenced by the controller.
- Generalises the fixed 2x2, 8-bit read/write memory to configurable pixel width and image size.
- Adds a command interface with a base address and length, valid/ready handshakes on both data sides with backpressure, and a one-word-per-cycle clear that maps onto block RAM.

---
 rtl/frame_buffer_pkg.sv | 26 ++
 rtl/frame_buffer_rwm_ram.sv | 36 +++
 rtl/frame_buffer_rwm.sv | 254 +++++++++++++++++++++++++
 tb/tb_frame_buffer_rwm.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared op encodings, FSM state type and address-width helper
// for the frame_buffer_rwm pixel store.
package frame_buffer_pkg;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CLEAR = 3'd3,
    ST_DONE  = 3'd4
  } fb_state_e;

  // Address width for a given word count; never narrower than one bit.
  function automatic int fb_addr_w(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/frame_buffer_rwm_ram.sv
// fb_ram: simple dual-port synchronous RAM, one write port and one registered
// read port with read enable (output holds when i_re is low). Storage has no reset.
module fb_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: one word per cycle when enabled.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; holds its last word while i_re is low.
  always_ff @(posedge clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_buffer_rwm.sv
// frame_buffer_rwm: parametrised pixel frame store with a command interface
// (read / write / clear over base+length), valid/ready pixel sides and a
// two-deep read prefetch (RAM read register + output skid register).
// Optional feature macro: FRAME_BUFFER_ROW_MARK_EN adds rd_sol/rd_eol markers.
module frame_buffer_rwm
  import frame_buffer_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 4,
  parameter  int IMG_H  = 4,
  localparam int DEPTH  = IMG_W * IMG_H,
  localparam int ADDR_W = fb_addr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_len,
  output logic              busy,
  output logic              done,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready
`ifdef FRAME_BUFFER_ROW_MARK_EN
  ,
  output logic              rd_sol,
  output logic              rd_eol
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1'b1);
  localparam logic [ADDR_W:0]   LEN_DEPTH = (ADDR_W+1)'(DEPTH);

  // Pointer advance modulo DEPTH (DEPTH need not be a power of two).
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    if (p == ADDR_LAST) begin
      return ADDR_ZERO;
    end else begin
      return p + ADDR_ONE;
    end
  endfunction

  fb_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
  logic [ADDR_W:0]   r_rem, w_rem_nxt;
  logic [ADDR_W:0]   w_len_eff;
  logic              r_busy, r_done, r_wr_ready;
  logic              r_s1_valid, r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              w_ram_we, w_ram_re;
  logic [ADDR_W-1:0] w_ram_raddr;
  logic [DATA_W-1:0] w_ram_wdata, w_ram_q;
  logic              w_rd_take, w_s2_load, w_s1_free;

  // Length 0 and over-long lengths both mean a whole frame.
  assign w_len_eff = ((cmd_len == LEN_ZERO) || (cmd_len > LEN_DEPTH)) ? LEN_DEPTH : cmd_len;

  // Read pipeline handshakes: stage 1 is the RAM read register, stage 2 the output.
  assign w_rd_take = r_rd_valid & rd_ready;
  assign w_s2_load = r_s1_valid & (~r_rd_valid | rd_ready);
  assign w_s1_free = ~r_s1_valid | w_s2_load;

  fb_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_ptr),
    .i_wdata (w_ram_wdata),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_q)
  );

  // Next-state, pointer/count and RAM port control.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_rem_nxt   = r_rem;
    w_ram_we    = 1'b0;
    w_ram_wdata = {DATA_W{1'b0}};
    w_ram_re    = 1'b0;
    w_ram_raddr = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_READ: begin
              // First word is fetched in the accept cycle so rd_valid appears
              // two cycles after the command; the pointer then holds the next word.
              w_state_nxt = ST_READ;
              w_ram_re    = 1'b1;
              w_ram_raddr = cmd_addr;
              w_ptr_nxt   = ptr_inc(cmd_addr);
              w_rem_nxt   = w_len_eff - LEN_ONE;
            end
            OP_WRITE: begin
              w_state_nxt = ST_WRITE;
              w_ptr_nxt   = cmd_addr;
              w_rem_nxt   = w_len_eff;
            end
            OP_CLEAR: begin
              w_state_nxt = ST_CLEAR;
              w_ptr_nxt   = cmd_addr;
              w_rem_nxt   = w_len_eff;
            end
            default: begin
              w_state_nxt = ST_IDLE;
            end
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_valid && r_wr_ready) begin
          w_ram_we    = 1'b1;
          w_ram_wdata = wr_data;
          w_ptr_nxt   = ptr_inc(r_ptr);
          w_rem_nxt   = r_rem - LEN_ONE;
          w_state_nxt = (r_rem == LEN_ONE) ? ST_DONE : ST_WRITE;
        end else begin
          w_state_nxt = ST_WRITE;
        end
      end
      ST_CLEAR: begin
        w_ram_we    = 1'b1;
        w_ptr_nxt   = ptr_inc(r_ptr);
        w_rem_nxt   = r_rem - LEN_ONE;
        w_state_nxt = (r_rem == LEN_ONE) ? ST_DONE : ST_CLEAR;
      end
      ST_READ: begin
        if ((r_rem != LEN_ZERO) && w_s1_free) begin
          w_ram_re  = 1'b1;
          w_ptr_nxt = ptr_inc(r_ptr);
          w_rem_nxt = r_rem - LEN_ONE;
        end else begin
          w_ram_re  = 1'b0;
        end
        // Finished once nothing is left to fetch or in flight and the last beat leaves.
        if ((r_rem == LEN_ZERO) && !r_s1_valid && w_rd_take) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pointer, count and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_ptr      <= ADDR_ZERO;
      r_rem      <= LEN_ZERO;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wr_ready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_rem      <= w_rem_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
      r_wr_ready <= (w_state_nxt == ST_WRITE);
    end
  end

  // Read prefetch: RAM read register occupancy plus the output skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= {DATA_W{1'b0}};
    end else begin
      if (w_ram_re) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end else begin
        r_s1_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_ram_q;
      end else if (w_rd_take) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= r_rd_valid;
      end
    end
  end

`ifdef FRAME_BUFFER_ROW_MARK_EN
  logic        r_s1_sol, r_s1_eol, r_rd_sol, r_rd_eol;
  logic [31:0] w_col;

  assign w_col = {{(32-ADDR_W){1'b0}}, w_ram_raddr} % 32'(IMG_W);

  // Row markers travel with each fetched word through both prefetch stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sol <= 1'b0;
      r_s1_eol <= 1'b0;
      r_rd_sol <= 1'b0;
      r_rd_eol <= 1'b0;
    end else begin
      if (w_ram_re) begin
        r_s1_sol <= (w_col == 32'd0);
        r_s1_eol <= (w_col == 32'(IMG_W - 1));
      end else begin
        r_s1_sol <= r_s1_sol;
        r_s1_eol <= r_s1_eol;
      end
      if (w_s2_load) begin
        r_rd_sol <= r_s1_sol;
        r_rd_eol <= r_s1_eol;
      end else if (w_rd_take) begin
        r_rd_sol <= 1'b0;
        r_rd_eol <= 1'b0;
      end else begin
        r_rd_sol <= r_rd_sol;
        r_rd_eol <= r_rd_eol;
      end
    end
  end

  assign rd_sol = r_rd_sol & r_rd_valid;
  assign rd_eol = r_rd_eol & r_rd_valid;
`endif

  assign busy     = r_busy;
  assign done     = r_done;
  assign wr_ready = r_wr_ready;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_frame_buffer_rwm.sv
// tb_frame_buffer_rwm: directed + randomized checks of frame_buffer_rwm against
// a word-array reference model of the frame store.
module tb_frame_buffer_rwm;

  localparam int DATA_W = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int DEPTH  = IMG_W * IMG_H;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b00;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [ADDR_W:0]   cmd_len = '0;
  logic              busy, done, wr_ready, rd_valid;
  logic              wr_valid = 1'b0;
  logic [DATA_W-1:0] wr_data = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_ready = 1'b0;
`ifdef FRAME_BUFFER_ROW_MARK_EN
  logic              rd_sol, rd_eol;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  frame_buffer_rwm #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .busy      (busy),
    .done      (done),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready)
`ifdef FRAME_BUFFER_ROW_MARK_EN
    ,
    .rd_sol    (rd_sol),
    .rd_eol    (rd_eol)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_len(input int len);
    return (len == 0 || len > DEPTH) ? DEPTH : len;
  endfunction

  // Present a command for one cycle; returns in the first cycle after acceptance.
  task automatic send_cmd(input logic [1:0] op, input int addr, input int len);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = ADDR_W'(addr);
    cmd_len   = (ADDR_W+1)'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // base < 0 gives random pixels, otherwise base, base+1, ...
  task automatic do_write(input int addr, input int len, input int base,
                          input int stall_after, input int stall_cycles, input string tag);
    int n, beats, cyc, stalled;
    logic [7:0] d;
    n = eff_len(len); beats = 0; cyc = 0; stalled = 0;
    send_cmd(2'b01, addr, len);
    while (beats < n && cyc < 200) begin
      chk({tag, "_wr_ready"}, wr_ready, 1);
      chk({tag, "_no_early_done"}, done, 0);
      if (beats == stall_after && stalled < stall_cycles) begin
        wr_valid = 1'b0;
        stalled++;
      end else begin
        d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + beats);
        wr_valid = 1'b1;
        wr_data  = d;
        ref_mem[(addr + beats) % DEPTH] = d;
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_valid = 1'b0;
    chk({tag, "_bounded"}, cyc < 200, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_wr_ready_drop"}, wr_ready, 0);
    chk({tag, "_busy_in_done"}, busy, 1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // mode 0: rd_ready high; 1: pattern 1,0,0 repeating; 2: random rd_ready.
  task automatic do_read(input int addr, input int len, input int mode, input string tag);
    int n, beats, cyc;
    logic [7:0] held;
    logic was_stall;
    n = eff_len(len); beats = 0; cyc = 0; was_stall = 1'b0; held = 8'h00;
    rd_ready = 1'b0;
    send_cmd(2'b00, addr, len);
    chk({tag, "_lat_c1"}, rd_valid, 0);
    @(negedge clk);
    chk({tag, "_lat_c2"}, rd_valid, 1);
    while (beats < n && cyc < 400) begin
      if (mode == 0) chk({tag, "_no_bubble"}, rd_valid, 1);
      if (was_stall) begin
        chk({tag, "_hold_valid"}, rd_valid, 1);
        chk({tag, "_hold_data"}, rd_data, held);
      end
      if (rd_valid) begin
        chk({tag, "_data"}, rd_data, ref_mem[(addr + beats) % DEPTH]);
`ifdef FRAME_BUFFER_ROW_MARK_EN
        chk({tag, "_sol"}, rd_sol, (((addr + beats) % DEPTH) % IMG_W) == 0);
        chk({tag, "_eol"}, rd_eol, (((addr + beats) % DEPTH) % IMG_W) == IMG_W - 1);
`endif
      end
      chk({tag, "_no_early_done"}, done, 0);
      case (mode)
        0:       rd_ready = 1'b1;
        1:       rd_ready = (cyc % 3 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      was_stall = rd_valid && !rd_ready;
      held = rd_data;
      if (rd_valid && rd_ready) beats++;
      @(negedge clk);
      cyc++;
    end
    rd_ready = 1'b0;
    chk({tag, "_bounded"}, cyc < 400, 1);
    chk({tag, "_beats"}, beats, n);
    chk({tag, "_valid_drop"}, rd_valid, 0);
    chk({tag, "_done"}, done, 1);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_no_valid_idle"}, rd_valid, 0);
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full frame write 0x10..0x1F then full read
    do_write(0, 0, 8'h10, -1, 0, "wr_full");
    do_read(0, 0, 0, "rd_full");
    for (int i = 0; i < DEPTH; i++) chk("model_full", ref_mem[i], 8'(8'h10 + i));

    // Writer stall after 2nd beat
    do_write(8, 4, -1, 2, 3, "wr_stall");
    do_read(8, 4, 0, "rd_stall");

    // Wrap-around write, then read mem[0..1]
    do_write(14, 4, 8'hA0, -1, 0, "wr_wrap");
    do_read(0, 2, 0, "rd_wrap");

    // Read backpressure
    do_read(0, 0, 1, "rd_bp");
    do_read(5, 7, 2, "rd_rand_bp");

    // Clear words 4..7; done exactly 5 cycles after acceptance
    send_cmd(2'b10, 4, 4);
    for (int k = 1; k <= 4; k++) begin
      chk("clr_no_done", done, 0);
      chk("clr_busy", busy, 1);
      chk("clr_no_wr_ready", wr_ready, 0);
      chk("clr_no_rd_valid", rd_valid, 0);
      @(negedge clk);
    end
    chk("clr_done", done, 1);
    @(negedge clk);
    chk("clr_done_1cyc", done, 0);
    chk("clr_idle", busy, 0);
    for (int i = 4; i < 8; i++) ref_mem[i] = 8'h00;
    do_read(0, 0, 0, "rd_after_clr");

    // Reserved op ignored
    send_cmd(2'b11, 3, 2);
    chk("op11_busy", busy, 0);
    chk("op11_done", done, 0);
    @(negedge clk);
    chk("op11_busy2", busy, 0);

    // Over-long length clamps to a full frame
    do_read(3, 20, 0, "rd_clamp");

    // Randomized write/read rounds
    for (int r = 0; r < 4; r++) begin
      int a, l;
      a = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH);
      do_write(a, l, -1, $urandom_range(0, 3), $urandom_range(0, 2), "wr_rand");
      do_read($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 2, "rd_rand");
    end

    // Reset at the 3rd beat of a read
    rd_ready = 1'b0;
    send_cmd(2'b00, 0, 8);
    rd_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_beat3_valid", rd_valid, 1);
    chk("rstmid_beat3_data", rd_data, ref_mem[2]);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_rd_valid", rd_valid, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    rd_ready = 1'b0;
    @(negedge clk);
    chk("rstmid_no_done", done, 0);
    rst_n = 1'b1;
    do_read(0, 0, 0, "rd_post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
